// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the TiniSOC core top and the pipeline controller.
// The slave modport is the controller side; the master modport is the core side.
interface pipe_ctrl_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 do_hazard;
    logic                 branch_taken;
    logic                 im_ready;
    logic                 dm_req;
    logic                 dm_ready;

    logic                 pc_enable;
    logic                 xREG1_enable;
    logic                 xREG1_flush;
    logic                 xREG2_enable;
    logic                 xREG2_flush;
    logic                 xREG3_enable;
    logic                 xREG4_enable;
    logic                 dm_timeout;
    logic [CNT_WIDTH-1:0] stall_count;
    logic [CNT_WIDTH-1:0] flush_count;

    modport master (
        output do_hazard, branch_taken, im_ready, dm_req, dm_ready,
        input  pc_enable, xREG1_enable, xREG1_flush, xREG2_enable, xREG2_flush,
               xREG3_enable, xREG4_enable, dm_timeout, stall_count, flush_count
    );

    modport slave (
        input  do_hazard, branch_taken, im_ready, dm_req, dm_ready,
        output pc_enable, xREG1_enable, xREG1_flush, xREG2_enable, xREG2_flush,
               xREG3_enable, xREG4_enable, dm_timeout, stall_count, flush_count
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline register sequencing for the 5-stage TiniSOC core: DM freeze, branch squash,
// load-use bubble and IM wait, highest priority first. Define PIPE_CTRL_PERF_EN for counters.
module pipe_ctrl #(
    parameter int DM_TIMEOUT = 15,
    parameter int CNT_WIDTH  = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    pipe_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        DM_WAIT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        dm_timeout_q, dm_timeout_d;

    logic        frozen;
    logic        pcEn, r1En, r1Fl, r2En, r2Fl, r3En, r4En;

    assign frozen = bus.dm_req & ~bus.dm_ready;

    // Outputs depend on the current state and inputs; a DM release is evaluated normally in the same cycle.
    always_comb begin
        pcEn         = 1'b1;
        r1En         = 1'b1;
        r1Fl         = 1'b0;
        r2En         = 1'b1;
        r2Fl         = 1'b0;
        r3En         = 1'b1;
        r4En         = 1'b1;
        state_d      = RUN;
        wcnt_d       = 4'd0;
        dm_timeout_d = dm_timeout_q;

        if (!reset_n) begin
            pcEn         = 1'b0;
            r1En         = 1'b0;
            r1Fl         = 1'b1;
            r2En         = 1'b0;
            r2Fl         = 1'b1;
            r3En         = 1'b0;
            r4En         = 1'b0;
            dm_timeout_d = 1'b0;
        end else if (frozen) begin
            pcEn    = 1'b0;
            r1En    = 1'b0;
            r2En    = 1'b0;
            r3En    = 1'b0;
            r4En    = 1'b0;
            state_d = (state_q == LD_STALL) ? LD_STALL : DM_WAIT;
            wcnt_d  = (wcnt_q == 4'hF) ? 4'hF : wcnt_q + 4'd1;
            if (wcnt_d >= 4'(DM_TIMEOUT)) begin
                dm_timeout_d = 1'b1;
            end
        end else if (bus.branch_taken) begin
            r1Fl = 1'b1;
            r2Fl = 1'b1;
        end else if (bus.do_hazard && (state_q == RUN)) begin
            pcEn    = 1'b0;
            r1En    = 1'b0;
            r2Fl    = 1'b1;
            state_d = LD_STALL;
        end else if (!bus.im_ready) begin
            pcEn = 1'b0;
            r1Fl = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= RUN;
            wcnt_q       <= 4'd0;
            dm_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            dm_timeout_q <= dm_timeout_d;
        end
    end

    assign bus.pc_enable    = pcEn;
    assign bus.xREG1_enable = r1En;
    assign bus.xREG1_flush  = r1Fl;
    assign bus.xREG2_enable = r2En;
    assign bus.xREG2_flush  = r2Fl;
    assign bus.xREG3_enable = r3En;
    assign bus.xREG4_enable = r4En;
    assign bus.dm_timeout   = dm_timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
    logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;

    // Both counters saturate at all-ones instead of wrapping.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (!pcEn && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
        if (!frozen && bus.branch_taken && !(&flush_count_q)) begin
            flush_count_d = flush_count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign bus.stall_count = stall_count_q;
    assign bus.flush_count = flush_count_q;
`else
    assign bus.stall_count = '0;
    assign bus.flush_count = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by randomized traffic,
// all compared against a cycle-level behavioural model of the control rules.
module tb_pipe_ctrl;

    localparam int DM_TIMEOUT = 15;
    localparam int CNT_WIDTH  = 16;
    localparam int CNT_MAX    = (1 << CNT_WIDTH) - 1;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    pipe_ctrl_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

    pipe_ctrl #(
        .DM_TIMEOUT(DM_TIMEOUT),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int assertionCount = 0;
    int failCount      = 0;

    // Reference model: whether a load-use bubble was just inserted, how long the current
    // DM wait has lasted, and the event totals the counters should report.
    bit bubblePending = 1'b0;
    int dmWaitCycles  = 0;
    bit timeoutSeen   = 1'b0;
    int stalls        = 0;
    int squashes      = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertionCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int capped(input int value);
        return (value > CNT_MAX) ? CNT_MAX : value;
    endfunction

    // Control vector order: {pc_en, r1_en, r1_flush, r2_en, r2_flush, r3_en, r4_en}.
    task automatic applyStimulus(input bit rstN, input bit hz, input bit br,
                                 input bit imr, input bit dq, input bit dr);
        bit       frozen;
        bit       hazardHonored;
        bit [6:0] expVec;
        logic [6:0] actVec;

        @(negedge clock);
        reset_n          = rstN;
        bus.do_hazard    = hz;
        bus.branch_taken = br;
        bus.im_ready     = imr;
        bus.dm_req       = dq;
        bus.dm_ready     = dr;
        #1;

        frozen        = dq && !dr;
        hazardHonored = !bubblePending && (dmWaitCycles == 0);

        if (!rstN)                     expVec = 7'b0010100;
        else if (frozen)               expVec = 7'b0000000;
        else if (br)                   expVec = 7'b1111111;
        else if (hz && hazardHonored)  expVec = 7'b0001111;
        else if (!imr)                 expVec = 7'b0111011;
        else                           expVec = 7'b1101011;

        actVec = {bus.pc_enable, bus.xREG1_enable, bus.xREG1_flush, bus.xREG2_enable,
                  bus.xREG2_flush, bus.xREG3_enable, bus.xREG4_enable};

        checkOutput("ctrl_vec", 32'(actVec), 32'(expVec));
        checkOutput("dm_timeout", 32'(bus.dm_timeout), 32'(timeoutSeen));
        checkOutput("stall_count", 32'(bus.stall_count), PERF ? 32'(capped(stalls)) : 32'd0);
        checkOutput("flush_count", 32'(bus.flush_count), PERF ? 32'(capped(squashes)) : 32'd0);

        @(posedge clock);
        if (!rstN) begin
            bubblePending = 1'b0;
            dmWaitCycles  = 0;
            timeoutSeen   = 1'b0;
            stalls        = 0;
            squashes      = 0;
        end else begin
            if (!expVec[6]) stalls++;
            if (!frozen && br) squashes++;
            if (frozen) begin
                dmWaitCycles++;
                if (dmWaitCycles >= DM_TIMEOUT) timeoutSeen = 1'b1;
            end else begin
                dmWaitCycles  = 0;
                bubblePending = !br && hz && hazardHonored;
            end
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 1, 0, 0);
    endtask

    task automatic resetCycle();
        applyStimulus(0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        reset_n          = 1'b0;
        bus.do_hazard    = 1'b0;
        bus.branch_taken = 1'b0;
        bus.im_ready     = 1'b1;
        bus.dm_req       = 1'b0;
        bus.dm_ready     = 1'b0;

        resetCycle();
        resetCycle();
        idleCycles(2);

        // Load-use pair: exactly one bubble.
        resetCycle();
        applyStimulus(1, 1, 0, 1, 0, 0);
        applyStimulus(1, 1, 0, 1, 0, 0);
        #1 checkOutput("tp_loaduse_stalls", 32'(bus.stall_count), PERF ? 32'd1 : 32'd0);
        idleCycles(1);

        // Branch squash overrides a simultaneous hazard.
        resetCycle();
        applyStimulus(1, 1, 1, 1, 0, 0);
        #1 checkOutput("tp_branch_flushes", 32'(bus.flush_count), PERF ? 32'd1 : 32'd0);
        checkOutput("tp_branch_stalls", 32'(bus.stall_count), 32'd0);
        idleCycles(1);

        // Three DM wait cycles then ready.
        resetCycle();
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 1, 1);
        #1 checkOutput("tp_dm_stalls", 32'(bus.stall_count), PERF ? 32'd3 : 32'd0);
        checkOutput("tp_dm_no_timeout", 32'(bus.dm_timeout), 32'd0);

        // Timeout after 20 wait cycles, sticky until reset.
        resetCycle();
        for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 1, 1);
        idleCycles(3);
        #1 checkOutput("tp_timeout_sticky", 32'(bus.dm_timeout), 32'd1);
        resetCycle();
        #1 checkOutput("tp_timeout_cleared", 32'(bus.dm_timeout), 32'd0);

        // Reset during a DM wait, then idle.
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 1, 1, 0);
        applyStimulus(0, 1, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 1, 0);
        idleCycles(2);

        // IM wait for two cycles.
        resetCycle();
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        idleCycles(1);

        // Hazard arriving during a freeze that follows a bubble.
        resetCycle();
        applyStimulus(1, 1, 0, 1, 0, 0);
        applyStimulus(1, 1, 0, 1, 1, 0);
        applyStimulus(1, 1, 0, 1, 1, 0);
        applyStimulus(1, 1, 0, 1, 1, 1);
        applyStimulus(1, 1, 0, 1, 0, 0);
        idleCycles(1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 99) != 0),
                          ($urandom_range(0, 99) < 30),
                          ($urandom_range(0, 99) < 15),
                          ($urandom_range(0, 99) < 80),
                          ($urandom_range(0, 99) < 35),
                          ($urandom_range(0, 99) < 40));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failCount);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Sequences the 5-stage pipeline registers (PC, xREG1..xREG4) of the TiniSOC core.
- Consumes `do_hazard` from the forwarding unit, the EX-stage branch decision, and the IM/DM ready handshakes.
- Drives per-stage enable/flush so load-use bubbles, branch squashes and memory waits are applied with fixed priority and exact cycle counts.
- Sits beside the forwarding unit in the core top; owns no datapath, only control.

Parameters:
- DM_TIMEOUT, 15, max consecutive DM wait cycles before `dm_timeout` is raised.
- CNT_WIDTH, 16, width of the performance counters (saturating).

Ports:
- clock  in  1  core clock, all state updates on rising edge
- reset_n  in  1  synchronous active-low reset
- do_hazard  in  1  load-use hazard from the forwarding unit (ID source matches EX load destination)
- branch_taken  in  1  EX-stage branch/jump resolved taken this cycle
- im_ready  in  1  instruction memory has valid data for the current PC
- dm_req  in  1  MEM-stage instruction accesses data memory
- dm_ready  in  1  data memory completes the access this cycle
- pc_enable  out  1  PC register load enable
- xREG1_enable  out  1  IF/ID load enable
- xREG1_flush  out  1  IF/ID loads a bubble (nop, all control zero)
- xREG2_enable  out  1  ID/EX load enable
- xREG2_flush  out  1  ID/EX loads a bubble
- xREG3_enable  out  1  EX/MEM load enable
- xREG4_enable  out  1  MEM/WB load enable
- dm_timeout  out  1  sticky DM-wait-overrun flag
- stall_count  out  CNT_WIDTH  cycles with pc_enable=0
- flush_count  out  CNT_WIDTH  taken-branch squash events

Behaviour:
- State register: RUN, LD_STALL, DM_WAIT (2 bits). Wait counter `wcnt`: 4 bits, sized for DM_TIMEOUT ≤ 15.
- Reset (reset_n=0 at an edge):
  - state=RUN, wcnt=0, dm_timeout=0, counters=0.
  - While reset_n=0, all enables are 0 and both flushes are 1.
  - Reset mid-operation aborts any stall or wait immediately.
- Outputs are combinational from state and inputs; state is registered. Priority is highest first.
- 1. DM freeze:
  - Condition: dm_req=1 and dm_ready=0.
  - All five enables 0; flushes 0; next state DM_WAIT; wcnt increments, saturating at 15.
  - When wcnt reaches DM_TIMEOUT, dm_timeout is set and held until reset.
  - On the cycle dm_ready=1: normal evaluation resumes that same cycle (zero-cycle release), and next state is RUN with wcnt=0.
  - dm_req=1 with dm_ready=1 in the same cycle causes no stall.
- 2. Branch squash:
  - Condition: branch_taken=1 and not frozen.
  - All enables 1; xREG1_flush=1; xREG2_flush=1; flush_count increments.
  - Overrides do_hazard and im_ready in that cycle, because the offending instructions are squashed.
  - Next state RUN.
- 3. Load-use stall:
  - Condition: do_hazard=1 and state=RUN.
  - pc_enable=0, xREG1_enable=0, xREG2_flush=1; xREG3/xREG4 enabled. Next state LD_STALL.
  - In LD_STALL, do_hazard is ignored and normal flow applies, so exactly one bubble is inserted per load-use pair. LD_STALL returns to RUN after one cycle.
  - A DM freeze during LD_STALL holds state LD_STALL until release.
- 4. IM wait:
  - Condition: im_ready=0.
  - pc_enable=0; xREG1_flush=1; downstream enabled.
  - No state change; duration is unbounded.
- Otherwise: all enables 1, flushes 0.
- An active flush takes effect only when the matching enable is 1. A flush asserted with its enable 0 is ignored by the pipeline registers.
- stall_count increments every non-reset cycle with pc_enable=0 and saturates at all-ones.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: stall_count and flush_count are implemented as above.
- Undefined: no counter flops; both outputs are tied to 0. Control behaviour is identical.

Test Plan:
- Load-use: do_hazard=1 for 2 cycles from RUN → cycle0 pc_enable=0, xREG1_enable=0, xREG2_flush=1; cycle1 all enables 1, flushes 0; stall_count=1.
- Branch with hazard: branch_taken=1 and do_hazard=1 together → xREG1_flush=1, xREG2_flush=1, pc_enable=1; flush_count=1, stall_count=0.
- DM wait: dm_req=1, dm_ready=0 for 3 cycles then 1 → enables 0 for exactly 3 cycles, all 1 on the ready cycle; stall_count=3; dm_timeout=0.
- Timeout: dm_ready held 0 for 20 cycles → dm_timeout rises after the 15th wait cycle; wcnt stays at 15; flag holds after dm_ready=1 until reset_n=0.
- Reset mid-stall: reset_n=0 asserted during DM_WAIT → next edge state=RUN, counters 0, dm_timeout 0; enables 0 and flushes 1 while low; all enables 1 after release with idle inputs.
- IM wait: im_ready=0 for 2 cycles → pc_enable=0, xREG1_flush=1, xREG2..xREG4_enable=1 for 2 cycles; state stays RUN.
